// File: rtl/seq_chunk_adder.sv
// Multi-cycle unsigned adder: WIDTH-bit operands summed CHUNK bits per clock through one adder slice.
// Optional subtract mode (cikar port) is compiled in when SEQ_CHUNK_ADDER_SUB_EN is defined.
module seq_chunk_adder #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] sayi1,
    input  logic [WIDTH-1:0] sayi2,
    input  logic             carry_in,
`ifdef SEQ_CHUNK_ADDER_SUB_EN
    input  logic             cikar,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH:0]   toplam,
    output logic [1:0]       state_dbg
);
    localparam int N  = WIDTH / CHUNK;
    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam logic [KW-1:0] LAST = KW'(N - 1);

    generate
        if (WIDTH < 2 || CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_params
            $error("seq_chunk_adder: WIDTH must be >= 2 and divisible by CHUNK");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] acc;
    logic             carry_reg;
    logic [KW-1:0]    k;

    logic [CHUNK:0]   chunk_sum;
    logic [WIDTH-1:0] acc_next;
    logic [WIDTH-1:0] b_load;
    logic             c_load;

    assign state_dbg = state;

`ifdef SEQ_CHUNK_ADDER_SUB_EN
    // Subtraction is A + ~B + 1: invert B on load and force the first carry.
    assign b_load = cikar ? ~sayi2 : sayi2;
    assign c_load = cikar | carry_in;
`else
    assign b_load = sayi2;
    assign c_load = carry_in;
`endif

    always_comb begin
        chunk_sum = {1'b0, a_reg[k*CHUNK +: CHUNK]}
                  + {1'b0, b_reg[k*CHUNK +: CHUNK]}
                  + (CHUNK+1)'(carry_reg);
        acc_next = acc;
        acc_next[k*CHUNK +: CHUNK] = chunk_sum[CHUNK-1:0];
    end

    // Handshake: start is taken on any edge where busy=0 (IDLE or DONE); done pulses
    // for one cycle when toplam is loaded, and toplam holds until the next completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            toplam    <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            acc       <= '0;
            carry_reg <= 1'b0;
            k         <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_reg     <= sayi1;
                        b_reg     <= b_load;
                        carry_reg <= c_load;
                        k         <= '0;
                        busy      <= 1'b1;
                        state     <= BUSY;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                BUSY: begin
                    acc       <= acc_next;
                    carry_reg <= chunk_sum[CHUNK];
                    if (k == LAST) begin
                        toplam <= {chunk_sum[CHUNK], acc_next};
                        done   <= 1'b1;
                        busy   <= 1'b0;
                        state  <= DONE;
                    end else begin
                        k <= k + KW'(1);
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_seq_chunk_adder.sv
// Self-checking bench for seq_chunk_adder: directed WIDTH=8/CHUNK=2 steps, then random
// sweeps over four further parameterisations; results flow through an expected queue.
module tb_seq_chunk_adder;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        cin;
    logic        busy;
    logic        done;
    logic [8:0]  toplam;
    logic [1:0]  state_dbg;
`ifdef SEQ_CHUNK_ADDER_SUB_EN
    logic        cikar;
`endif

    logic [3:0]  start_s;
    logic [15:0] sw_a;
    logic [15:0] sw_b;
    logic        sw_ci;
    logic [3:0]  busy_s;
    logic [3:0]  done_s;
    logic [7:0]  dbg_s;
    logic [8:0]  t0, t1, t2;
    logic [16:0] t3;

    logic [16:0] exp_q[$];
    logic [16:0] last_toplam;
    int          checks;
    int          errors;

    always #5 clk = ~clk;

    seq_chunk_adder #(.WIDTH(8), .CHUNK(2)) dut (
        .clk(clk), .rst(rst), .start(start), .sayi1(a), .sayi2(b), .carry_in(cin),
`ifdef SEQ_CHUNK_ADDER_SUB_EN
        .cikar(cikar),
`endif
        .busy(busy), .done(done), .toplam(toplam), .state_dbg(state_dbg)
    );

    seq_chunk_adder #(.WIDTH(8), .CHUNK(1)) dut_w8c1 (
        .clk(clk), .rst(rst), .start(start_s[0]), .sayi1(sw_a[7:0]), .sayi2(sw_b[7:0]), .carry_in(sw_ci),
`ifdef SEQ_CHUNK_ADDER_SUB_EN
        .cikar(1'b0),
`endif
        .busy(busy_s[0]), .done(done_s[0]), .toplam(t0), .state_dbg(dbg_s[1:0])
    );

    seq_chunk_adder #(.WIDTH(8), .CHUNK(4)) dut_w8c4 (
        .clk(clk), .rst(rst), .start(start_s[1]), .sayi1(sw_a[7:0]), .sayi2(sw_b[7:0]), .carry_in(sw_ci),
`ifdef SEQ_CHUNK_ADDER_SUB_EN
        .cikar(1'b0),
`endif
        .busy(busy_s[1]), .done(done_s[1]), .toplam(t1), .state_dbg(dbg_s[3:2])
    );

    seq_chunk_adder #(.WIDTH(8), .CHUNK(8)) dut_w8c8 (
        .clk(clk), .rst(rst), .start(start_s[2]), .sayi1(sw_a[7:0]), .sayi2(sw_b[7:0]), .carry_in(sw_ci),
`ifdef SEQ_CHUNK_ADDER_SUB_EN
        .cikar(1'b0),
`endif
        .busy(busy_s[2]), .done(done_s[2]), .toplam(t2), .state_dbg(dbg_s[5:4])
    );

    seq_chunk_adder #(.WIDTH(16), .CHUNK(4)) dut_w16c4 (
        .clk(clk), .rst(rst), .start(start_s[3]), .sayi1(sw_a), .sayi2(sw_b), .carry_in(sw_ci),
`ifdef SEQ_CHUNK_ADDER_SUB_EN
        .cikar(1'b0),
`endif
        .busy(busy_s[3]), .done(done_s[3]), .toplam(t3), .state_dbg(dbg_s[7:6])
    );

    task automatic check(input string tag, input logic [16:0] obs, input logic [16:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one operation on the main DUT; returns just after the accepting edge.
    task automatic launch(input logic [7:0] op_a, input logic [7:0] op_b, input logic ci,
                          input logic sub, input logic [8:0] exp, input bit push);
        a     = op_a;
        b     = op_b;
        cin   = ci;
`ifdef SEQ_CHUNK_ADDER_SUB_EN
        cikar = sub;
`else
        if (sub) $display("note: subtract step skipped in add-only build");
`endif
        start = 1'b1;
        if (push) exp_q.push_back(17'(exp));
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Count edges from acceptance to done; optionally pokes start mid-operation.
    task automatic wait_done(input int n_exp, input string tag, input bit poke);
        int j;
        int busy_cnt;
        logic [16:0] e;
        j = 0;
        busy_cnt = 0;
        while (j < 40) begin
            @(negedge clk);
            if (done) break;
            if (busy) busy_cnt++;
            check({tag, "_hold"}, 17'(toplam), last_toplam);
            if (poke && j == 1) begin
                start = 1'b1;
                a = 8'($urandom);
                b = 8'($urandom);
                cin = 1'($urandom);
            end
            if (poke && j == 2) start = 1'b0;
            j++;
        end
        e = exp_q.pop_front();
        check({tag, "_latency"}, 17'(j), 17'(n_exp));
        check({tag, "_busy_cycles"}, 17'(busy_cnt), 17'(n_exp));
        check({tag, "_toplam"}, 17'(toplam), e);
        check({tag, "_busy_at_done"}, 17'(busy), 17'(0));
        check({tag, "_state_done"}, 17'(state_dbg), 17'(2));
        last_toplam = e;
    endtask

    function automatic logic [16:0] sweep_t(input int idx);
        case (idx)
            0: return 17'(t0);
            1: return 17'(t1);
            2: return 17'(t2);
            default: return t3;
        endcase
    endfunction

    task automatic sweep(input int idx, input int w, input int n, input string tag);
        logic [15:0] ra;
        logic [15:0] rb;
        logic        rc;
        logic [16:0] e;
        int j;
        for (int it = 0; it < 1000; it++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rc = 1'($urandom);
            if (w == 8) begin
                ra[15:8] = 8'h00;
                rb[15:8] = 8'h00;
            end
            sw_a  = ra;
            sw_b  = rb;
            sw_ci = rc;
            start_s[idx] = 1'b1;
            exp_q.push_back(17'(ra) + 17'(rb) + 17'(rc));
            @(posedge clk);
            #1 start_s[idx] = 1'b0;
            for (j = 0; j < 40; j++) begin
                @(negedge clk);
                if (done_s[idx]) break;
            end
            e = exp_q.pop_front();
            check({tag, "_latency"}, 17'(j), 17'(n));
            check({tag, "_toplam"}, sweep_t(idx), e);
            check({tag, "_busy_at_done"}, 17'(busy_s[idx]), 17'(0));
            check({tag, "_state"}, 17'(dbg_s[2*idx +: 2]), 17'(2));
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        last_toplam = '0;
        rst = 1'b1;
        start = 1'b0;
        a = '0;
        b = '0;
        cin = 1'b0;
`ifdef SEQ_CHUNK_ADDER_SUB_EN
        cikar = 1'b0;
`endif
        start_s = '0;
        sw_a = '0;
        sw_b = '0;
        sw_ci = 1'b0;

        // Reset held for two edges, with a start request that must be dropped.
        @(negedge clk);
        start = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check("rst_busy", 17'(busy), 17'(0));
        check("rst_done", 17'(done), 17'(0));
        check("rst_toplam", 17'(toplam), 17'(0));
        check("rst_state", 17'(state_dbg), 17'(0));
        rst = 1'b0;
        @(negedge clk);
        check("idle_busy", 17'(busy), 17'(0));
        check("idle_toplam", 17'(toplam), 17'(0));

        launch(8'hFF, 8'h01, 1'b0, 1'b0, 9'h100, 1'b1);
        wait_done(4, "add_ff_01", 1'b0);
        @(negedge clk);
        check("done_single_pulse", 17'(done), 17'(0));
        check("idle_after_done", 17'(state_dbg), 17'(0));

        // Back-to-back: second start is presented during the DONE cycle.
        launch(8'h7F, 8'h80, 1'b1, 1'b0, 9'h100, 1'b1);
        wait_done(4, "add_cin", 1'b0);
        launch(8'h12, 8'h34, 1'b0, 1'b0, 9'h046, 1'b1);
        wait_done(4, "b2b_second", 1'b0);
        @(negedge clk);

        launch(8'h5A, 8'hC3, 1'b1, 1'b0, 9'h11E, 1'b1);
        wait_done(4, "ignored_start", 1'b1);
        @(negedge clk);
        check("ignored_start_idle", 17'(state_dbg), 17'(0));

        // Abort two cycles into BUSY.
        @(negedge clk);
        launch(8'h33, 8'h44, 1'b0, 1'b0, 9'h077, 1'b0);
        @(negedge clk);
        check("abort_busy_before", 17'(busy), 17'(1));
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("abort_busy", 17'(busy), 17'(0));
        check("abort_done", 17'(done), 17'(0));
        check("abort_toplam", 17'(toplam), 17'(0));
        check("abort_state", 17'(state_dbg), 17'(0));
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("abort_no_done", 17'(done), 17'(0));
        end
        last_toplam = '0;

`ifdef SEQ_CHUNK_ADDER_SUB_EN
        launch(8'h05, 8'h03, 1'b0, 1'b1, 9'h102, 1'b1);
        wait_done(4, "sub_05_03", 1'b0);
        launch(8'h03, 8'h05, 1'b1, 1'b1, 9'h0FE, 1'b1);
        wait_done(4, "sub_03_05", 1'b0);
        launch(8'h03, 8'h05, 1'b1, 1'b0, 9'h009, 1'b1);
        wait_done(4, "add_mode_cin", 1'b0);
        @(negedge clk);
`endif

        sweep(0, 8, 8, "w8c1");
        sweep(1, 8, 2, "w8c4");
        sweep(2, 8, 1, "w8c8");
        sweep(3, 16, 4, "w16c4");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
